// File: rtl/team_01_gpio_change_capture_if.sv
// Purpose: bundles the enable, observed GPIO bus, read strobe and FIFO status of the change-capture block.
// Latency: none; this is wiring only.
// Backpressure: the reader pops with rd_en and watches valid; nothing stalls the observed bus.
interface team_01_gpio_change_capture_if #(
  parameter int DEPTH   = 4,
  parameter int STAMP_W = 16
);
  logic                       en;
  logic [33:0]                gpio_out;
  logic                       rd_en;
  logic                       clr_ovf;
  logic [33:0]                rd_data;
  logic [STAMP_W-1:0]         rd_stamp;
  logic                       valid;
  logic                       full;
  logic                       overflow;
  logic [$clog2(DEPTH):0]     count;

  // Controller / reader side.
  modport master (
    output en, gpio_out, rd_en, clr_ovf,
    input  rd_data, rd_stamp, valid, full, overflow, count
  );

  // Capture block side.
  modport slave (
    input  en, gpio_out, rd_en, clr_ovf,
    output rd_data, rd_stamp, valid, full, overflow, count
  );
endinterface

// File: rtl/team_01_gpio_change_capture.sv
// Purpose: timestamps every change on the observed GPIO output bus into a small first-word-fall-through FIFO.
// Latency: a change sampled at edge k is at the FIFO head right after edge k.
// Backpressure: none upstream; a change arriving while full and not popped is dropped and flags overflow.
module team_01_gpio_change_capture #(
  parameter int DEPTH   = 4,
  parameter int STAMP_W = 16
) (
  input logic                     clk,
  input logic                     nrst,
  team_01_gpio_change_capture_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  typedef struct packed {
    logic [33:0]        dat;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  state_t             state;
  logic [STAMP_W-1:0] stamp;
  logic [33:0]        prev;

  entry_t             mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               overflow;

  logic               change;
  logic               is_full;
  logic               is_empty;
  logic               do_pop;
  logic               do_push;
  logic               drop;

  // Only a RUN cycle with the block enabled may record a transition.
  assign change   = (state == RUN) && bus.en && (bus.gpio_out != prev);
  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);
  // A pop on an empty FIFO is silently ignored.
  assign do_pop   = bus.rd_en && !is_empty;
  // When full, a simultaneous pop frees the slot the new entry takes.
  assign do_push  = change && (!is_full || do_pop);
  assign drop     = change && is_full && !do_pop;

  // Sequencer: ARM takes the snapshot so the value present at enable is never reported.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      stamp <= '0;
      prev  <= '0;
    end else if (!bus.en) begin
      state <= IDLE;
      stamp <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= ARM;
        end
        ARM: begin
          state <= RUN;
          prev  <= bus.gpio_out;
          stamp <= stamp + STAMP_W'(1);
        end
        RUN: begin
          prev  <= bus.gpio_out;
          stamp <= stamp + STAMP_W'(1);
        end
        default: begin
          state <= IDLE;
          stamp <= '0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless until the matching count says otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{dat: bus.gpio_out, stamp: stamp};
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!nrst) overflow <= 1'b0;
    else       overflow <= drop | (overflow & ~bus.clr_ovf);
  end

  assign bus.valid    = !is_empty;
  assign bus.full     = is_full;
  assign bus.overflow = overflow;
  assign bus.count    = count;
  // Head is gated to zero when empty so reset presents clean zeros.
  assign bus.rd_data  = is_empty ? '0 : mem[rd_ptr].dat;
  assign bus.rd_stamp = is_empty ? '0 : mem[rd_ptr].stamp;

endmodule

// File: tb/tb_team_01_gpio_change_capture.sv
// Purpose: directed stimulus with a scoreboard queue checked by an independent pop monitor.
// Latency: expects a change at edge k to sit at the FIFO head right after edge k.
// Backpressure: reader pops driven directly; drops are expected only when full without a pop.
module tb_team_01_gpio_change_capture;

  localparam int DEPTH   = 4;
  localparam int STAMP_W = 4;

  typedef struct packed {
    logic [33:0]        dat;
    logic [STAMP_W-1:0] stamp;
  } exp_t;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;
  int   n;
  exp_t sb_q [$];

  team_01_gpio_change_capture_if #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) bus ();

  team_01_gpio_change_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (act timeout, req finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // n counts enabled edges since the block was last idle; the edge sampling
  // the next input has stamp n-1 once n>=2 (edge 1 leaves IDLE, edge 2 is ARM).
  task automatic tick();
    @(posedge clk);
    if (!nrst || !bus.en) n = 0;
    else                  n++;
    #1;
  endtask

  task automatic chg(input logic [33:0] v, input bit exp_push);
    exp_t e;
    bus.gpio_out = v;
    if (exp_push) begin
      e.dat   = v;
      e.stamp = STAMP_W'(n - 1);
      sb_q.push_back(e);
    end
    tick();
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (nrst && bus.valid && bus.rd_en) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: actual data %0h stamp %0h, required no entry", bus.rd_data, bus.rd_stamp);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pop_data", 64'(bus.rd_data), 64'(e.dat));
        check("pop_stamp", 64'(bus.rd_stamp), 64'(e.stamp));
      end
    end
  end

  initial begin
    logic [33:0] a [5];
    logic [33:0] b [7];
    tests = 0;
    fails = 0;
    n     = 0;
    nrst         = 1'b0;
    bus.en       = 1'b0;
    bus.gpio_out = '0;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_data", 64'(bus.rd_data), 64'd0);
    check("rst_stamp", 64'(bus.rd_stamp), 64'd0);
    nrst = 1'b1;

    // Constant value at enable is absorbed by ARM.
    bus.gpio_out = 34'h0_0000_0005;
    bus.en       = 1'b1;
    repeat (20) tick();
    check("arm_valid", 64'(bus.valid), 64'd0);
    check("arm_count", 64'(bus.count), 64'd0);

    // Restart and change in stamp cycle 7.
    bus.en = 1'b0;
    tick();
    bus.en = 1'b1;
    for (int i = 0; i < 20 && n < 8; i++) tick();
    chg(34'h2_0000_0001, 1'b1);
    check("first_valid", 64'(bus.valid), 64'd1);
    check("first_count", 64'(bus.count), 64'd1);
    check("first_data", 64'(bus.rd_data), 64'h2_0000_0001);
    check("first_stamp", 64'(bus.rd_stamp), 64'd7);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("first_popped", 64'(bus.valid), 64'd0);

    // Pop on empty is harmless.
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("empty_pop_count", 64'(bus.count), 64'd0);
    check("empty_pop_valid", 64'(bus.valid), 64'd0);

    // Fill, overflow on the fifth, drain in order, clear.
    a = '{34'h0_0000_00A1, 34'h0_0000_00A2, 34'h0_0000_00A3, 34'h0_0000_00A4, 34'h0_0000_00A5};
    for (int i = 0; i < 4; i++) chg(a[i], 1'b1);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_count", 64'(bus.count), 64'd4);
    check("fill_ovf", 64'(bus.overflow), 64'd0);
    chg(a[4], 1'b0);
    check("drop_ovf", 64'(bus.overflow), 64'd1);
    check("drop_count", 64'(bus.count), 64'd4);
    bus.rd_en = 1'b1;
    repeat (4) tick();
    bus.rd_en = 1'b0;
    check("drain_valid", 64'(bus.valid), 64'd0);
    check("drain_ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr_ovf", 64'(bus.overflow), 64'd0);

    // Drop coinciding with clear keeps the flag; full push+pop keeps count.
    b = '{34'h1_0000_00B1, 34'h1_0000_00B2, 34'h1_0000_00B3, 34'h1_0000_00B4,
          34'h1_0000_00B5, 34'h1_0000_00B6, 34'h1_0000_00B7};
    for (int i = 0; i < 4; i++) chg(b[i], 1'b1);
    chg(b[4], 1'b0);
    check("drop2_ovf", 64'(bus.overflow), 64'd1);
    bus.clr_ovf = 1'b1;
    chg(b[5], 1'b0);
    check("clr_vs_drop_ovf", 64'(bus.overflow), 64'd1);
    tick();
    bus.clr_ovf = 1'b0;
    check("clr2_ovf", 64'(bus.overflow), 64'd0);
    bus.rd_en = 1'b1;
    chg(b[6], 1'b1);
    bus.rd_en = 1'b0;
    check("full_pushpop_count", 64'(bus.count), 64'd4);
    check("full_pushpop_ovf", 64'(bus.overflow), 64'd0);
    check("full_pushpop_head", 64'(bus.rd_data), 64'(b[1]));
    bus.rd_en = 1'b1;
    repeat (2) tick();
    bus.rd_en = 1'b0;
    check("two_left_count", 64'(bus.count), 64'd2);

    // Disabled: toggles ignored, contents retained.
    bus.en = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.gpio_out = (i % 2 == 0) ? 34'h0_5555_5555 : 34'h3_AAAA_AAAA;
      tick();
    end
    check("idle_count", 64'(bus.count), 64'd2);
    check("idle_head", 64'(bus.rd_data), 64'(b[3]));
    bus.en = 1'b1;
    chg(34'h0_0000_0C01, 1'b0);
    chg(34'h0_0000_0C02, 1'b0);
    check("rearm_count", 64'(bus.count), 64'd2);
    chg(34'h0_0000_0C03, 1'b1);
    check("rearm_push_count", 64'(bus.count), 64'd3);
    bus.rd_en = 1'b1;
    repeat (3) tick();
    bus.rd_en = 1'b0;
    check("rearm_drained", 64'(bus.valid), 64'd0);

    // Changes every 5 cycles, read every cycle, stamps wrap mod 16.
    bus.rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chg(34'h3_0000_0000 | 34'(k + 1), 1'b1);
      repeat (4) tick();
    end
    bus.rd_en = 1'b0;
    tick();
    check("wrap_drained", 64'(bus.count), 64'd0);

    // Reset mid-run discards contents and flags; re-arm before pushing.
    for (int k = 0; k < 5; k++) chg(34'h0_0ABC_0000 + 34'(k + 1), 1'b0);
    check("pre_rst_full", 64'(bus.full), 64'd1);
    nrst = 1'b0;
    tick();
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_full", 64'(bus.full), 64'd0);
    check("midrst_ovf", 64'(bus.overflow), 64'd0);
    check("midrst_data", 64'(bus.rd_data), 64'd0);
    nrst = 1'b1;
    chg(34'h0_0000_0E01, 1'b0);
    chg(34'h0_0000_0E02, 1'b0);
    check("post_rst_arm_count", 64'(bus.count), 64'd0);
    chg(34'h0_0000_0E03, 1'b1);
    check("post_rst_push_count", 64'(bus.count), 64'd1);
    check("post_rst_stamp", 64'(bus.rd_stamp), 64'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/team_01_gpio_change_capture.md
TEAM_01_GPIO_CHANGE_CAPTURE -- requirements
Module: team_01_gpio_change_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter STAMP_W, default 16: timestamp width.
REQ-003 SHALL have port clk  input  1  design clock (wb_clk_i domain).
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  design enable; capture runs only while high.
REQ-006 SHALL have port gpio_out  input  34  observed output bus, packed as {gpio[37:5], gpio[0]}.
REQ-007 SHALL have port rd_en  input  1  pop strobe for the head entry.
REQ-008 SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-009 SHALL have port rd_data  output  34  head-entry GPIO value.
REQ-010 SHALL have port rd_stamp  output  STAMP_W  head-entry timestamp.
REQ-011 SHALL have port valid  output  1  FIFO non-empty.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: a change was dropped.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL implement the states IDLE, ARM and RUN: IDLE->ARM when en=1; ARM->RUN unconditionally; ARM or RUN->IDLE when en=0.
REQ-016 SHALL hold the stamp counter at 0 in IDLE, and in ARM and RUN SHALL increment it by 1 per cycle, wrapping modulo 2^STAMP_W.
REQ-017 SHALL load the snapshot register prev with gpio_out in ARM without pushing an entry.
REQ-018 SHALL, in RUN, push {gpio_out, stamp} at the clock edge whenever gpio_out != prev, where stamp is the counter value in that cycle before increment.
REQ-019 SHALL update prev with gpio_out every RUN cycle, so each distinct transition is pushed exactly once.
REQ-020 SHALL freeze prev in IDLE, retain FIFO contents and keep them poppable while en=0.
REQ-021 SHALL give the FIFO first-word-fall-through behaviour: rd_data and rd_stamp show the head whenever valid=1, and the head advances on the edge where rd_en=1 and valid=1.
REQ-022 SHALL make a pushed entry visible one cycle after detection: change sampled at edge k gives valid=1 and the entry at the head after edge k (when the FIFO was empty).
REQ-023 SHALL ignore rd_en when the FIFO is empty: no pointer change, no error.
REQ-024 SHALL, on push and pop in the same cycle with the FIFO non-empty (full included), perform both and leave count unchanged.
REQ-025 SHALL, on push with the FIFO empty and rd_en=1, accept the push and perform no pop.
REQ-026 SHALL, on push with the FIFO full and no pop, drop the entry, set overflow=1 and leave contents unchanged.
REQ-027 SHALL keep overflow set until clr_ovf=1, and SHALL leave overflow set when clr_ovf and a new drop occur in the same cycle.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 SHALL keep count exact (0..DEPTH), with full = (count==DEPTH) and valid = (count!=0).
REQ-030 SHALL leave rd_data and rd_stamp don't-care while valid=0.
REQ-031 SHALL NOT drive the GPIO pads; the block is observe-only.

Reset
REQ-032 SHALL, while nrst=0 at a clock edge: enter IDLE, set the stamp counter to 0, set prev to 0, set both pointers and count to 0, and set overflow=0, valid=0 and full=0.
REQ-033 SHALL, when reset is asserted mid-RUN, discard all FIFO contents; after nrst rises with en=1, go through ARM before any push.
REQ-034 SHALL drive rd_data and rd_stamp to 0 in reset.

Verification
REQ-035 SHALL pass this scenario: nrst low 2 cycles, then en=1 with gpio_out constant 34'h0_0000_0005 for 20 cycles -> valid stays 0 and count=0 (ARM suppresses the initial value).
REQ-036 SHALL pass this scenario: RUN, gpio_out changes 5->34'h2_0000_0001 in stamp cycle 7 -> next cycle valid=1, rd_data=34'h2_0000_0001, rd_stamp=7, count=1; pulse rd_en -> valid=0.
REQ-037 SHALL pass this scenario: DEPTH=4, five consecutive distinct changes with no reads -> full=1 after the 4th and overflow=1 after the 5th; popping 4 times returns the first four values in order; clr_ovf -> overflow=0.
REQ-038 SHALL pass this scenario: FIFO full, a change with rd_en=1 in the same cycle -> count stays 4, old head removed, new entry at the tail, overflow stays 0.
REQ-039 SHALL pass this scenario: en drops with 2 entries queued, then gpio_out toggles 10 times -> no pushes, 2 entries remain readable; en re-rises -> stamp restarts at 0, first cycle armed, no push.
REQ-040 SHALL pass this scenario: STAMP_W=4, a change every 5 cycles for 40 cycles -> rd_stamp sequence wraps modulo 16 with no change lost while it is read every cycle.
